// File: rtl/calc_pkg.sv
// Shared definitions for the operator scheduler: default data width,
// FSM state encoding and the requester-id width helper.
package calc_pkg;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  // Width of a binary requester index; never below 1 bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/op_scheduler_if.sv
// Request/response and operator-side signals of the scheduler.
// master = requesters + operator, slave = scheduler.
interface op_scheduler_if
  import calc_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = DW_DEFAULT
);
  localparam int ID_W = clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               operation_enable;
  logic [DW-1:0]      op_data;
  logic [DW-1:0]      op_result;
  logic               rsp_valid;
  logic [ID_W-1:0]    rsp_id;
  logic [DW-1:0]      rsp_data;

  modport master (
    output req_valid, req_data, op_result,
    input  req_ready, operation_enable, op_data, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_data, op_result,
    output req_ready, operation_enable, op_data, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above
// ptr, wrapping to 0; returns one-hot grant and its binary index.
module rr_arbiter
  import calc_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int ID_W = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [ID_W-1:0] grant_id
);
  int idx;

  // Scan from the farthest candidate down so the nearest one wins last.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NREQ;
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end
endmodule

// File: rtl/op_scheduler.sv
// Shares one fixed-latency operator among NREQ requesters: round-robin
// grant, issue strobe, latency wait, tagged result. Optional counters
// under OP_SCHEDULER_STATS_EN.
module op_scheduler
  import calc_pkg::*;
#(
  parameter int NREQ       = 3,
  parameter int OP_LATENCY = 2,
  parameter int DW         = DW_DEFAULT
) (
  input  logic          clk_100MHz,
  input  logic          rst_n,
  op_scheduler_if.slave bus,
  output logic [DW-1:0] disp_data,
  output logic          busy
`ifdef OP_SCHEDULER_STATS_EN
  ,
  output logic [15:0]   op_count,
  output logic [15:0]   stall_count
`endif
);
  localparam int ID_W = clog2(NREQ);

  state_t          state, state_nx;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] arb_id, grant_id, rr_ptr;
  logic [3:0]      cnt;
  logic            take;

  rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req      (bus.req_valid),
    .ptr      (rr_ptr),
    .grant    (grant),
    .grant_id (arb_id)
  );

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    take     = 1'b0;
    case (state)
      IDLE:    if (|bus.req_valid) begin
                 take     = 1'b1;
                 state_nx = ISSUE;
               end
      ISSUE:   state_nx = WAIT;
      WAIT:    if (cnt == 4'd0) state_nx = CAPTURE;
      CAPTURE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Accept is combinational; masked while reset is held.
  assign bus.req_ready = (take && rst_n) ? grant : '0;
  assign busy          = (state != IDLE);

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      bus.operation_enable <= 1'b0;
      bus.op_data          <= '0;
      bus.rsp_valid        <= 1'b0;
      bus.rsp_id           <= '0;
      bus.rsp_data         <= '0;
      disp_data            <= '0;
      grant_id             <= '0;
      rr_ptr               <= '0;
      cnt                  <= '0;
    end else begin
      bus.operation_enable <= take;
      bus.rsp_valid        <= 1'b0;
      if (take) begin
        bus.op_data <= bus.req_data[arb_id*DW +: DW];
        grant_id    <= arb_id;
      end
      case (state)
        ISSUE:   cnt <= 4'(OP_LATENCY - 1);
        WAIT:    cnt <= cnt - 4'd1;
        CAPTURE: begin
          bus.rsp_data  <= bus.op_result;
          disp_data     <= bus.op_result;
          bus.rsp_id    <= grant_id;
          bus.rsp_valid <= 1'b1;
          rr_ptr        <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef OP_SCHEDULER_STATS_EN
  // op_count wraps; stall_count saturates.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (state == CAPTURE) op_count <= op_count + 16'd1;
      if (busy && |bus.req_valid && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif
endmodule
